// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the registered ALU control decoder and
// its iterative multiply/divide sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b0010;
    localparam logic [3:0] OP_BNE = 4'b0011;
    localparam logic [3:0] OP_R   = 4'b0100;
    localparam logic [3:0] OP_SET = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011001;
    localparam logic [5:0] FN_DIV = 6'b011011;

    localparam logic [3:0] AC_ADD = 4'b0000;
    localparam logic [3:0] AC_SUB = 4'b0001;
    localparam logic [3:0] AC_AND = 4'b0010;
    localparam logic [3:0] AC_OR  = 4'b0011;
    localparam logic [3:0] AC_XOR = 4'b0100;
    localparam logic [3:0] AC_BEQ = 4'b0101;
    localparam logic [3:0] AC_NOR = 4'b0110;
    localparam logic [3:0] AC_SLT = 4'b0111;
    localparam logic [3:0] AC_MUL = 4'b1000;
    localparam logic [3:0] AC_DIV = 4'b1001;
    localparam logic [3:0] AC_SET = 4'b1110;
    localparam logic [3:0] AC_ERR = 4'b1111;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared shift register datapath: one bit per step of unsigned
// shift-add multiply or restoring divide.
module alu_iter_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              step,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, lo_q, b_q;
    logic [DATA_W:0]   madd, drem, dsub;

    // hi holds partial product / remainder, lo the multiplier / quotient
    always_comb begin
        madd = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        drem = {hi_q, lo_q[DATA_W-1]};
        dsub = drem - {1'b0, b_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= a;
            b_q  <= b;
        end else if (step) begin
            if (mode == MODE_DIV) begin
                if (!dsub[DATA_W]) begin
                    hi_q <= dsub[DATA_W-1:0];
                    lo_q <= {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_q <= drem[DATA_W-1:0];
                    lo_q <= {lo_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                hi_q <= madd[DATA_W:1];
                lo_q <= {madd[0], lo_q[DATA_W-1:1]};
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a start/busy/done sequencer
// for iterative unsigned MULTU/DIVU producing HI/LO.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6,
    parameter int AC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [FUNC_W-1:0] fun_code,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [AC_W-1:0]   ac_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CW = $clog2(DATA_W) + 1;

    state_t            st, nx;
    logic [CW-1:0]     cnt;
    logic [AC_W-1:0]   dec_ac, ac_q;
    logic              dec_err, dec_mul, dec_div;
    logic              load, step, last, accept, div0;
    logic              done_q, err_q;
    logic [DATA_W-1:0] hi_q, lo_q, dp_hi, dp_lo;

    always_comb begin
        dec_ac  = AC_ERR;
        dec_err = 1'b1;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        case (alu_op)
            OP_LW, OP_SW, OP_JMP: begin dec_ac = AC_ADD; dec_err = 1'b0; end
            OP_BEQ: begin dec_ac = AC_BEQ; dec_err = 1'b0; end
            OP_BNE: begin dec_ac = AC_SUB; dec_err = 1'b0; end
            OP_SET: begin dec_ac = AC_SET; dec_err = 1'b0; end
            OP_R: begin
                dec_err = 1'b0;
                case (fun_code)
                    FN_ADD: dec_ac = AC_ADD;
                    FN_SUB: dec_ac = AC_SUB;
                    FN_AND: dec_ac = AC_AND;
                    FN_OR:  dec_ac = AC_OR;
                    FN_XOR: dec_ac = AC_XOR;
                    FN_NOR: dec_ac = AC_NOR;
                    FN_SLT: dec_ac = AC_SLT;
                    FN_MUL: begin dec_ac = AC_MUL; dec_mul = 1'b1; end
                    FN_DIV: begin dec_ac = AC_DIV; dec_div = 1'b1; end
                    default: begin dec_ac = AC_ERR; dec_err = 1'b1; end
                endcase
            end
            default: ;
        endcase
    end

    assign accept = (st == S_IDLE) && start;
    assign div0   = dec_div && (src_b == '0);
    assign last   = (cnt == CW'(DATA_W - 1));

    always_comb begin
        nx   = st;
        load = 1'b0;
        step = 1'b0;
        case (st)
            S_IDLE: begin
                if (start && dec_mul) begin
                    nx   = S_MUL;
                    load = 1'b1;
                end else if (start && dec_div && !div0) begin
                    nx   = S_DIV;
                    load = 1'b1;
                end
            end
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (last) nx = S_FIN;
            end
            S_FIN: nx = S_IDLE;
            default: nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= S_IDLE;
            cnt    <= '0;
            ac_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            st     <= nx;
            done_q <= 1'b0;
            if (load) cnt <= '0;
            else if (step) cnt <= cnt + CW'(1);
            if (accept) begin
                ac_q <= dec_ac;
                if (div0) begin
                    err_q  <= 1'b1;
                    hi_q   <= src_a;
                    lo_q   <= '1;
                    done_q <= 1'b1;
                end else begin
                    err_q  <= dec_err;
                    done_q <= !(dec_mul || dec_div);
                end
            end
            if (st == S_FIN) begin
                hi_q <= dp_hi;
                lo_q <= dp_lo;
            end
        end
    end

    alu_iter_muldiv #(.DATA_W(DATA_W)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .mode ((st == S_DIV) ? MODE_DIV : MODE_MUL),
        .a    (src_a),
        .b    (src_b),
        .step (step),
        .hi_o (dp_hi),
        .lo_o (dp_lo)
    );

    // FIN shows the fresh result directly; it is captured on the way out
    assign hi     = (st == S_FIN) ? dp_hi : hi_q;
    assign lo     = (st == S_FIN) ? dp_lo : lo_q;
    assign ac_out = ac_q;
    assign err    = err_q;
    assign busy   = (st == S_MUL) || (st == S_DIV);
    assign done   = done_q || (st == S_FIN);

endmodule

// File: tb/tb_alu_control_seq.sv
// Table-driven scoreboard bench for alu_control_seq.
module tb_alu_control_seq;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  fc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ac;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]  ac;
        logic        err;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          upd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [5:0]  fun_code = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [3:0]  ac_out;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;
    exp_t q[$];
    vec_t tbl[$];

    alu_control_seq dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .fun_code(fun_code), .src_a(src_a), .src_b(src_b),
        .ac_out(ac_out), .busy(busy), .done(done), .err(err),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exv);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [5:0] fc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] ac, input logic e);
        vec_t v;
        v.op = op; v.fc = fc; v.a = a; v.b = b; v.ac = ac; v.err = e;
        return v;
    endfunction

    task automatic run(input vec_t v, input bit noisy, input string nm);
        exp_t e;
        logic [63:0] p;
        int n, bc;
        bit got;
        e.ac = v.ac; e.err = v.err; e.hi = mh; e.lo = ml;
        e.lat = 1; e.upd = 1'b0;
        if (v.ac == 4'b1000) begin
            p = {32'b0, v.a} * {32'b0, v.b};
            e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; e.upd = 1'b1;
        end else if (v.ac == 4'b1001) begin
            e.upd = 1'b1;
            if (v.b == 0) begin
                e.hi = v.a; e.lo = 32'hFFFF_FFFF;
            end else begin
                e.hi = v.a % v.b; e.lo = v.a / v.b; e.lat = 33;
            end
        end
        q.push_back(e);
        @(negedge clk);
        alu_op = v.op; fun_code = v.fc; src_a = v.a; src_b = v.b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got = 0; bc = 0; n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n = i;
            if (done) begin got = 1; break; end
            if (busy) bc++;
            if (noisy && (i == 5 || i == 20)) begin
                alu_op = 4'b0100; fun_code = 6'b011011;
                src_a = $urandom; src_b = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
                src_a = $urandom; src_b = $urandom;
            end
        end
        start = 1'b0;
        e = q.pop_front();
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout actual=no_done required=done", nm);
        end else begin
            chk({nm, "_lat"}, n, e.lat);
            chk({nm, "_busycyc"}, bc, e.lat - 1);
            chk({nm, "_busy_at_done"}, busy, 0);
            chk({nm, "_ac"}, ac_out, e.ac);
            chk({nm, "_err"}, err, e.err);
            chk({nm, "_hi"}, hi, e.hi);
            chk({nm, "_lo"}, lo, e.lo);
            if (e.upd) begin mh = e.hi; ml = e.lo; end
            @(negedge clk);
            chk({nm, "_done_pulse"}, done, 0);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ac"}, ac_out, 4'b0000);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_hi"}, hi, 0);
        chk({nm, "_lo"}, lo, 0);
    endtask

    initial begin
        tbl.push_back(mk(4'b0000, 6'b000000, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b0001, 6'b000000, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b0010, 6'b000000, 1, 2, 4'b0101, 0));
        tbl.push_back(mk(4'b0011, 6'b000000, 1, 2, 4'b0001, 0));
        tbl.push_back(mk(4'b0101, 6'b000000, 1, 2, 4'b1110, 0));
        tbl.push_back(mk(4'b0110, 6'b000000, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b0111, 6'b000000, 1, 2, 4'b1111, 1));
        tbl.push_back(mk(4'b0011, 6'b000000, 1, 2, 4'b0001, 0));
        tbl.push_back(mk(4'b0100, 6'b100000, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b0100, 6'b100010, 1, 2, 4'b0001, 0));
        tbl.push_back(mk(4'b0100, 6'b100100, 1, 2, 4'b0010, 0));
        tbl.push_back(mk(4'b0100, 6'b100101, 1, 2, 4'b0011, 0));
        tbl.push_back(mk(4'b0100, 6'b100110, 1, 2, 4'b0100, 0));
        tbl.push_back(mk(4'b0100, 6'b100111, 1, 2, 4'b0110, 0));
        tbl.push_back(mk(4'b0100, 6'b101010, 1, 2, 4'b0111, 0));
        tbl.push_back(mk(4'b0100, 6'b111111, 1, 2, 4'b1111, 1));
        tbl.push_back(mk(4'b0011, 6'b000000, 1, 2, 4'b0001, 0));
        tbl.push_back(mk(4'b0100, 6'b011001, 32'hFFFF_FFFF, 2, 4'b1000, 0));
        tbl.push_back(mk(4'b0100, 6'b100111, 7, 9, 4'b0110, 0));
        tbl.push_back(mk(4'b0100, 6'b011011, 100, 7, 4'b1001, 0));
        tbl.push_back(mk(4'b0100, 6'b011011, 5, 0, 4'b1001, 1));
        tbl.push_back(mk(4'b0000, 6'b000000, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b0100, 6'b011001, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1000, 0));
        tbl.push_back(mk(4'b0100, 6'b011011, 32'hFFFF_FFFF, 32'h10, 4'b1001, 0));
        tbl.push_back(mk(4'b0100, 6'b011011, 32'h8000_0001, 32'hFFFF_FFFF, 4'b1001, 0));
        tbl.push_back(mk(4'b1111, 6'b100000, 1, 2, 4'b1111, 1));
        tbl.push_back(mk(4'b0000, 6'b011001, 3, 4, 4'b0000, 0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // start pulses mid-MUL must be ignored
        run(mk(4'b0100, 6'b011001, 32'h1234_5678, 32'h0000_9ABC, 4'b1000, 0),
            1'b1, "noisy_mul");

        // reset in the middle of a MUL
        @(negedge clk);
        alu_op = 4'b0100; fun_code = 6'b011001;
        src_a = 32'hCAFE_F00D; src_b = 32'h77; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mh = '0; ml = '0;
        @(negedge clk);
        chk_reset("midreset");
        repeat (40) @(negedge clk);
        chk("midreset_no_late_done", done, 0);
        chk("midreset_hi_kept", hi, 0);

        run(tbl[13], 1'b0, "post_nor");
        run(tbl[22], 1'b0, "post_mul");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
